shift_out_register: RTL and testbench

- Parallel-in, serial-out shifter. It is the transmit end of the bit-serial datapath and the counterpart of the serial-in capture register on the bit-serial adder.
- It accepts a WIDTH-bit word through a valid/ready handshake and emits it LSB first, one bit per enabled clock.
- A capture register that shifts right with new bits entering at the MSB therefore reconstructs the original word after WIDTH bits.
- Supports pacing via shift_en and back-to-back words with no idle gap.

---
 rtl/shift_out_register.sv | 98 +++++++++
 tb/tb_shift_out_register.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_out_register.sv
// -----------------------------------------------------------------------------
// shift_out_register
//
// Parallel-in, serial-out transmitter for the bit-serial datapath. A WIDTH-bit
// word is accepted through a valid/ready handshake and emitted LSB first, one
// bit per clock on which shift_en is high. A capture register that shifts right
// (new bits entering at the MSB) reconstructs the word after WIDTH enabled bits.
// A follow-on word may be accepted on the edge that consumes the final bit. This
// gives a gapless stream.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   load_valid  data_in holds a word to transmit
//   data_in     parallel word, sampled on the handshake edge
//   load_ready  block can accept a word this cycle
//   shift_en    advance one bit this cycle (pacing / stall)
//   serial_out  current bit (LSB of the shift register)
//   bit_valid   serial_out carries a valid data bit
//   last        serial_out is bit WIDTH-1 of the word
//   done        one-cycle pulse after a word finishes with no follow-on word
// -----------------------------------------------------------------------------
module shift_out_register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] data_in,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             bit_valid,
    output logic             last,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;

    // Outputs are decoded from the state register so that they drop at once
    // when reset is asserted, even in the middle of a word.
    assign bit_valid  = (state == SHIFT);
    assign serial_out = bit_valid & shreg[0];
    assign last       = bit_valid && (cnt == CNT_LAST);
    // Ready during the final enabled bit lets the next word follow with no gap.
    assign load_ready = (state == IDLE) || (last && shift_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        shreg <= data_in;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (shift_en) begin
                        if (cnt == CNT_LAST) begin
                            if (load_valid) begin
                                shreg <= data_in;
                                cnt   <= '0;
                            end else begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        end else begin
                            shreg <= {1'b0, shreg[WIDTH-1:1]};
                            cnt   <= cnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_out_register.sv
module tb_shift_out_register;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load_valid = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         shift_en = 1'b0;
    logic         load_ready, serial_out, bit_valid, last, done;

    int checks = 0;
    int errors = 0;

    shift_out_register #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .data_in    (data_in),
        .load_ready (load_ready),
        .shift_en   (shift_en),
        .serial_out (serial_out),
        .bit_valid  (bit_valid),
        .last       (last),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Serial-in capture register clocked by bit_valid & shift_en.
    logic [W-1:0] cap = '0;
    always @(posedge clk) begin
        if (bit_valid && shift_en) cap <= {serial_out, cap[W-1:1]};
    end

    // Reference model: queue of bits still owed to the consumer.
    bit           q[$];
    logic         exp_done = 1'b0;
    logic         cur_lv, cur_se;
    logic [W-1:0] cur_d;
    // {serial_out, bit_valid, last, load_ready, done}
    logic [4:0]   exp_vec, act_vec;

    task automatic step(input logic lv, input logic [W-1:0] d, input logic se);
        @(negedge clk);
        load_valid = lv;
        data_in    = d;
        shift_en   = se;
        cur_lv = lv; cur_d = d; cur_se = se;
        #1;
        exp_vec = {(q.size() > 0) ? logic'(q[0]) : 1'b0,
                   q.size() > 0,
                   q.size() == 1,
                   (q.size() == 0) || (q.size() == 1 && se),
                   exp_done};
        act_vec = {serial_out, bit_valid, last, load_ready, done};
    endtask

    task automatic commit();
        logic acc, fin;
        acc = cur_lv && ((q.size() == 0) || (q.size() == 1 && cur_se));
        fin = (q.size() == 1) && cur_se;
        @(posedge clk);
        if (cur_se && q.size() > 0) void'(q.pop_front());
        if (acc) for (int i = 0; i < W; i++) q.push_back(cur_d[i]);
        exp_done = fin && !acc;
    endtask

    task automatic model_reset();
        q.delete();
        exp_done = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({serial_out, bit_valid, last, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=0000", {serial_out, bit_valid, last, done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(0, '0, 1);
        checks++;
        if (act_vec !== 5'b00010) begin
            errors++;
            $display("FAIL reset_idle got=%b want=00010", act_vec);
        end
        commit();
    endtask

    task automatic test_basic();
        logic [W-1:0] w;
        w = 8'hB5;
        step(1, w, 1);
        checks++;
        if (act_vec !== exp_vec) begin errors++; $display("FAIL basic_load got=%b want=%b", act_vec, exp_vec); end
        commit();
        for (int i = 0; i < W; i++) begin
            step(0, '0, 1);
            checks++;
            if (act_vec !== exp_vec) begin errors++; $display("FAIL basic_model bit%0d got=%b want=%b", i, act_vec, exp_vec); end
            checks++;
            if ({serial_out, bit_valid, last} !== {w[i], 1'b1, i == W - 1}) begin
                errors++;
                $display("FAIL basic_bit%0d got=%b want=%b", i, {serial_out, bit_valid, last}, {w[i], 1'b1, i == W - 1});
            end
            commit();
        end
        step(0, '0, 1);
        checks++;
        if ({done, load_ready, bit_valid} !== 3'b110) begin
            errors++;
            $display("FAIL basic_done got=%b want=110", {done, load_ready, bit_valid});
        end
        commit();
        step(0, '0, 1);
        checks++;
        if (act_vec !== 5'b00010) begin errors++; $display("FAIL basic_done_once got=%b want=00010", act_vec); end
        commit();
    endtask

    task automatic test_loopback();
        logic [W-1:0] words [2];
        words[0] = 8'h3C;
        words[1] = 8'hFF;
        for (int k = 0; k < 2; k++) begin
            step(1, words[k], 1);
            checks++;
            if (act_vec !== exp_vec) begin errors++; $display("FAIL loop_load got=%b want=%b", act_vec, exp_vec); end
            commit();
            for (int i = 0; i < W; i++) begin
                step(0, '0, 1);
                checks++;
                if (act_vec !== exp_vec) begin errors++; $display("FAIL loop_model got=%b want=%b", act_vec, exp_vec); end
                commit();
            end
            #1;
            checks++;
            if (cap !== words[k]) begin errors++; $display("FAIL loop_capture got=%h want=%h", cap, words[k]); end
            step(0, '0, 0);
            commit();
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] bits;
        int dones;
        bits  = 16'h8001;
        dones = 0;
        step(1, 8'h01, 1);
        commit();
        for (int i = 0; i < 16; i++) begin
            step(i < W, 8'h80, 1);
            checks++;
            if (act_vec !== exp_vec) begin errors++; $display("FAIL b2b_model c%0d got=%b want=%b", i, act_vec, exp_vec); end
            checks++;
            if ({bit_valid, serial_out} !== {1'b1, bits[i]}) begin
                errors++;
                $display("FAIL b2b_bit%0d got=%b want=%b", i, {bit_valid, serial_out}, {1'b1, bits[i]});
            end
            if (done) dones++;
            commit();
        end
        for (int i = 0; i < 3; i++) begin
            step(0, '0, 1);
            if (done) dones++;
            commit();
        end
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL b2b_done_count got=%0d want=1", dones); end
    endtask

    task automatic test_stall();
        int en_bits, cyc;
        logic se;
        step(1, 8'hA5, 1);
        commit();
        en_bits = 0;
        cyc = 0;
        while (en_bits < W && cyc < 40) begin
            se = (cyc % 3) == 0;
            step(0, '0, se);
            checks++;
            if (act_vec !== exp_vec) begin errors++; $display("FAIL stall_model c%0d got=%b want=%b", cyc, act_vec, exp_vec); end
            if (bit_valid && se) en_bits++;
            commit();
            cyc++;
        end
        checks++;
        if (en_bits !== W) begin errors++; $display("FAIL stall_timeout got=%0d bits want=%0d", en_bits, W); end
        step(0, '0, 0);
        checks++;
        if ({done, cap} !== {1'b1, 8'hA5}) begin
            errors++;
            $display("FAIL stall_result got=%b/%h want=1/a5", done, cap);
        end
        commit();
    endtask

    task automatic test_reset_mid();
        step(1, 8'hF0, 1);
        commit();
        for (int i = 0; i < 3; i++) begin
            step(0, '0, 1);
            commit();
        end
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({serial_out, bit_valid, last, done} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_outputs got=%b want=0000", {serial_out, bit_valid, last, done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(0, '0, 1);
        checks++;
        if (act_vec !== 5'b00010) begin errors++; $display("FAIL midreset_idle got=%b want=00010", act_vec); end
        commit();
        step(1, 8'h0F, 1);
        commit();
        for (int i = 0; i < W; i++) begin
            step(0, '0, 1);
            checks++;
            if (act_vec !== exp_vec) begin errors++; $display("FAIL midreset_model got=%b want=%b", act_vec, exp_vec); end
            commit();
        end
        #1;
        checks++;
        if (cap !== 8'h0F) begin errors++; $display("FAIL midreset_capture got=%h want=0f", cap); end
    endtask

    task automatic test_blocking();
        step(1, 8'hC3, 1);
        commit();
        for (int i = 0; i < 2 * W; i++) begin
            step(i < W, 8'h55, 1);
            checks++;
            if (act_vec !== exp_vec) begin errors++; $display("FAIL block_model c%0d got=%b want=%b", i, act_vec, exp_vec); end
            if (i < W) begin
                checks++;
                if (load_ready !== (i == W - 1)) begin
                    errors++;
                    $display("FAIL block_ready c%0d got=%b want=%b", i, load_ready, i == W - 1);
                end
            end
            commit();
            if (i == W - 1) begin
                #1;
                checks++;
                if (cap !== 8'hC3) begin errors++; $display("FAIL block_first got=%h want=c3", cap); end
            end
        end
        #1;
        checks++;
        if (cap !== 8'h55) begin errors++; $display("FAIL block_second got=%h want=55", cap); end
    endtask

    task automatic test_random();
        logic         pend, se, acc;
        logic [W-1:0] word;
        pend = 1'b0;
        word = '0;
        for (int c = 0; c < 400; c++) begin
            if (!pend && ($urandom % 3) == 0) begin
                pend = 1'b1;
                word = W'($urandom);
            end
            se = ($urandom % 4) != 0;
            step(pend, word, se);
            checks++;
            if (act_vec !== exp_vec) begin errors++; $display("FAIL random c%0d got=%b want=%b", c, act_vec, exp_vec); end
            acc = pend && exp_vec[1];
            commit();
            if (acc) pend = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_loopback();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_blocking();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
